// File: rtl/rgb_led_pkg.sv
// RGB LED sequencer shared definitions.
// Colour codes, button indices and the brightness level restored at reset.
package rgb_led_pkg;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    localparam int BTN_LOAD = 0;
    localparam int BTN_NEXT = 1;
    localparam int BTN_DIM  = 2;
    localparam int BTN_CLR  = 3;

    localparam logic [1:0] LVL_RESET = 2'd3;

endpackage

// File: rtl/rgb_led_sequencer_btn_debounce.sv
// Button conditioning: 2-flop synchroniser, stability debouncer,
// and rising-edge detector producing a one-cycle press pulse.
module btn_debounce #(
    parameter int DEB_CNT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CNT - 1);

    logic          s1_q, s2_q;
    logic          stab_q, stab_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive disagreeing cycles; accept the new level on the last one.
    always_comb begin
        stab_d = stab_q;
        cnt_d  = '0;
        if (s2_q != stab_q) begin
            if (cnt_q == LAST) begin
                stab_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, debounce state and edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            stab_q <= 1'b0;
            cnt_q  <= '0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= btn_i;
            s2_q   <= s1_q;
            stab_q <= stab_d;
            cnt_q  <= cnt_d;
            prev_q <= stab_q;
        end
    end

    assign press_o = stab_q & ~prev_q;

endmodule

// File: rtl/rgb_led_sequencer.sv
// RGB LED sequencer: per-LED colour registers, selection, brightness
// level and a shared PWM driving registered colour outputs.
module rgb_led_sequencer
    import rgb_led_pkg::*;
#(
    parameter int N_LED   = 2,
    parameter int PWM_W   = 8,
    parameter int DEB_CNT = 1000000,
    localparam int SEL_W  = (N_LED > 1) ? $clog2(N_LED) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       sw,
    input  logic [3:0]       btn,
    output logic [N_LED-1:0] led_r,
    output logic [N_LED-1:0] led_g,
    output logic [N_LED-1:0] led_b,
    output logic [SEL_W-1:0] sel
);

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_LED - 1);

    logic [3:0]       press;
    logic [2:0]       col_q [N_LED];
    logic [2:0]       col_d [N_LED];
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [1:0]       lvl_q, lvl_d;
    logic [PWM_W-1:0] cnt_q;
    logic [PWM_W:0]   thr;
    logic             pwm_on;
    logic [N_LED-1:0] r_q, g_q, b_q;

    for (genvar k = 0; k < 4; k++) begin : g_btn
        btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_i  (btn[k]),
            .press_o(press[k])
        );
    end

    // Clear beats load; load targets the selection before any increment.
    always_comb begin
        col_d = col_q;
        sel_d = sel_q;
        lvl_d = lvl_q + {1'b0, press[BTN_DIM]};
        if (press[BTN_CLR]) begin
            for (int i = 0; i < N_LED; i++) col_d[i] = BLACK;
        end else if (press[BTN_LOAD]) begin
            col_d[sel_q] = sw;
        end
        if (press[BTN_NEXT]) begin
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        end
    end

    assign thr = ({{(PWM_W-1){1'b0}}, lvl_q} + {{PWM_W{1'b0}}, 1'b1})
                 << (PWM_W - 2);
    assign pwm_on = {1'b0, cnt_q} < thr;

    // Control registers, PWM counter and gated colour outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_LED; i++) col_q[i] <= BLACK;
            sel_q <= '0;
            lvl_q <= LVL_RESET;
            cnt_q <= '0;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
        end else begin
            col_q <= col_d;
            sel_q <= sel_d;
            lvl_q <= lvl_d;
            cnt_q <= cnt_q + 1'b1;
            for (int i = 0; i < N_LED; i++) begin
                r_q[i] <= col_q[i][2] & pwm_on;
                g_q[i] <= col_q[i][1] & pwm_on;
                b_q[i] <= col_q[i][0] & pwm_on;
            end
        end
    end

    assign led_r = r_q;
    assign led_g = g_q;
    assign led_b = b_q;
    assign sel   = sel_q;

endmodule

// File: tb/tb_rgb_led_sequencer.sv
// Testbench for rgb_led_sequencer with a cycle-level reference model.
// Press latency: state changes on edge 2+DEB_CNT+1, counting the first edge that samples the raw press.
module tb_rgb_led_sequencer;

    localparam int N   = 2;
    localparam int PW  = 4;
    localparam int D   = 4;
    localparam int LAT = 2 + D + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   sw = 3'b000;
    logic [3:0]   btn = 4'b0000;
    logic [N-1:0] led_r, led_g, led_b;
    logic         sel;

    int nvec = 0;
    int nerr = 0;
    bit chk_on = 1'b0;

    rgb_led_sequencer #(.N_LED(N), .PWM_W(PW), .DEB_CNT(D)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sw   (sw),
        .btn  (btn),
        .led_r(led_r),
        .led_g(led_g),
        .led_b(led_b),
        .sel  (sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    bit [2:0]   mcol [N];
    int         msel, mlvl, mcnt;
    bit [3:0]   mstab, mpend;
    bit [N-1:0] mr, mg, mb;
    bit [3:0]   hist [$];

    task automatic mreset();
        for (int i = 0; i < N; i++) mcol[i] = 3'b000;
        msel = 0; mlvl = 3; mcnt = 0;
        mstab = 0; mpend = 0;
        mr = 0; mg = 0; mb = 0;
        hist.delete();
        repeat (D + 2) hist.push_back(4'b0000);
    endtask

    task automatic mstep();
        bit on;
        bit diff;
        bit [3:0] newp;
        on = mcnt < (mlvl + 1) * (1 << (PW - 2));
        for (int i = 0; i < N; i++) begin
            mr[i] = mcol[i][2] & on;
            mg[i] = mcol[i][1] & on;
            mb[i] = mcol[i][0] & on;
        end
        if (mpend[3]) begin
            for (int i = 0; i < N; i++) mcol[i] = 3'b000;
        end else if (mpend[0]) begin
            mcol[msel] = sw;
        end
        if (mpend[1]) msel = (msel + 1) % N;
        if (mpend[2]) mlvl = (mlvl + 1) % 4;
        mcnt = (mcnt + 1) % (1 << PW);
        newp = 0;
        for (int b = 0; b < 4; b++) begin
            diff = 1'b1;
            for (int j = 0; j < D; j++)
                if (hist[1 + j][b] == mstab[b]) diff = 1'b0;
            if (diff) begin
                mstab[b] = ~mstab[b];
                newp[b] = mstab[b];
            end
        end
        mpend = newp;
        hist.push_front(btn);
        void'(hist.pop_back());
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mreset();
        else mstep();
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("led_r", 32'(led_r), 32'(mr));
            chk("led_g", 32'(led_g), 32'(mg));
            chk("led_b", 32'(led_b), 32'(mb));
            chk("sel", 32'(sel), 32'(msel));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        btn = m;
        cyc(hold);
        btn = 4'b0000;
        cyc(12);
    endtask

    task automatic duty(input string tag, input int want);
        int ones;
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            ones += int'(led_r[0]);
        end
        chk(tag, 32'(ones), 32'(want));
    endtask

    initial begin
        cyc(3);
        chk_on = 1'b1;
        chk("rst_led_r", 32'(led_r), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // Load red into LED 0, full brightness
        sw = 3'b100;
        press(4'b0001, 10);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("red0_r", 32'(led_r), 32'b01);
            chk("red0_g", 32'(led_g | led_b), 32'b00);
        end

        // Short bounce must not load
        sw = 3'b010;
        press(4'b0001, 3);
        chk("bounce_r", 32'(led_r), 32'b01);
        chk("bounce_g", 32'(led_g), 32'b00);

        // Exact press latency on next
        btn = 4'b0010;
        cyc(LAT - 1);
        chk("lat_early", 32'(sel), 32'd0);
        cyc(1);
        chk("lat_exact", 32'(sel), 32'd1);
        btn = 4'b0000;
        cyc(12);
        press(4'b0010, 10);
        chk("sel_wrap", 32'(sel), 32'd0);
        press(4'b0010, 10);
        sw = 3'b011;
        press(4'b0001, 10);
        chk("cyan1_g", 32'(led_g), 32'b10);
        chk("cyan1_b", 32'(led_b), 32'b10);
        chk("cyan1_r", 32'(led_r), 32'b01);

        // Brightness: lvl 0 is 4/16, back to lvl 3 is 16/16
        press(4'b0100, 10);
        duty("duty_lvl0", 4);
        press(4'b0100, 10);
        press(4'b0100, 10);
        press(4'b0100, 10);
        duty("duty_lvl3", 16);

        // Clear overrides load in the same cycle
        sw = 3'b111;
        press(4'b1001, 10);
        chk("clr_r", 32'(led_r), 32'b00);
        chk("clr_gb", 32'(led_g | led_b), 32'b00);

        // Load with simultaneous next lands on old selection
        sw = 3'b101;
        press(4'b0011, 10);
        chk("ldnx_r", 32'(led_r), 32'b10);
        chk("ldnx_b", 32'(led_b), 32'b10);
        chk("ldnx_sel", 32'(sel), 32'd0);

        // Reset mid-PWM and mid-debounce with next held
        btn = 4'b0010;
        cyc(5);
        rst_n = 1'b0;
        #1;
        chk("arst_r", 32'(led_r), 32'd0);
        chk("arst_b", 32'(led_b), 32'd0);
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        chk("rel_sel", 32'(sel), 32'd0);
        btn = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("rel_hold", 32'(sel), 32'd0);
        end

        // Randomised traffic against the model
        for (int s = 0; s < 400; s++) begin
            logic [3:0] m;
            for (int b = 0; b < 4; b++)
                m[b] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) sw = 3'($urandom_range(0, 7));
            btn = m;
            cyc($urandom_range(1, 12));
            if ($urandom_range(0, 60) == 0) begin
                rst_n = 1'b0;
                cyc($urandom_range(1, 3));
                rst_n = 1'b1;
            end
        end
        btn = 4'b0000;
        cyc(20);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
